irq_pending_latch: RTL and testbench
====================================

Name: irq_pending_latch

Overview:
- Request-capture stage sitting directly upstream of the 8-to-3 priority encoder.
- Synchronises 8 asynchronous interrupt lines, detects events, and holds each one as a sticky pending bit until it is acknowledged by id.
- Drives the encoder's i[7:0] input (pend_o) and its en input (en_o).
- The encoder's y output is returned as ack_id once the event is serviced.

Parameters:
- N, 8, number of request lines.
- IDW, 3, width of ack_id; equals clog2(N).
- SYNC_STAGES, 2, synchroniser flops per line; 0 means inputs are already synchronous.
- EDGE_MODE, 1, 1 = rising-edge capture, 0 = level capture.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- irq_in  input  N  raw request lines.
- mask  input  N  1 = line enabled for output; masking never clears latched state.
- ack  input  1  one-cycle acknowledge strobe.
- ack_id  input  IDW  index of the line being acknowledged.
- ovf_clr  input  1  one-cycle strobe clearing all overrun flags.
- pend_o  output  N  masked pending vector to the priority encoder.
- en_o  output  1  OR of pend_o; encoder enable.
- ovf_o  output  N  sticky per-line overrun flags.

Behaviour:
- Interface fact: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset: rst_n=0 at a rising clk edge clears sync flops, s_d, pend_q and ovf_q.
  - pend_o=0, en_o=0, ovf_o=0 from that edge onward.
  - Reset mid-operation discards all pending events and overrun flags.
- Synchroniser: s = irq_in after SYNC_STAGES flops.
- Event detect:
  - EDGE_MODE=1: rise = s & ~s_d, where s_d is s registered.
  - EDGE_MODE=0: rise = s.
  - A line held high across reset release counts as one edge, because s_d resets to 0.
- Latency: irq_in first sampled high at edge t -> pend_q bit set at edge t+SYNC_STAGES -> pend_o/en_o valid in the following cycle.
- Clear: clr[k] = ack & (ack_id==k).
  - ack_id >= N, or ack to a non-pending bit: no effect; no error flag.
- Pending update: pend_q[k] <= (pend_q[k] & ~clr[k]) | rise[k].
  - Set wins over clear. A new event in the same cycle as its ack leaves the bit pending.
  - Level mode: the bit re-asserts every cycle while the line stays high.
- Overrun (EDGE_MODE=1 only):
  - Set: ovf_q[k] <= 1 when rise[k] & pend_q[k] & ~clr[k].
  - Clear: ovf_clr clears all bits.
  - A same-cycle set wins over ovf_clr.
  - Overrun events are not queued; the bit stays a single pending event.
  - With EDGE_MODE=0, ovf_o is tied to 0.
- Outputs:
  - pend_o = pend_q & mask (combinational AND of register and mask).
  - en_o = |pend_o; ovf_o = ovf_q.
  - Unmasking a latched bit raises pend_o in the same cycle.
- Only one ack per cycle; multiple-id ack is not supported.

Decomposition:
- Shared package irq_pkg:
  - IRQ_N=8 and IRQ_IDW=3 constants.
  - typedef irq_vec_t = logic [IRQ_N-1:0].
  - typedef irq_id_t = logic [IRQ_IDW-1:0].
- The priority encoder consumes the same constants.
- Sub-module irq_sync_edge: per-line SYNC_STAGES flop chain plus s_d register, with outputs s and rise; instantiated N times via generate.
- The pending/overrun logic stays in the top module.

Test Plan:
- Reset then single edge, SYNC_STAGES=2: irq_in=8'h80 pulsed 1 cycle -> pend_o=8'h80 and en_o=1 visible after 2 edges; ack with ack_id=7 -> pend_o=0, en_o=0 next cycle.
- Multiple pending: irq_in edges on 8'h14 -> pend_o=8'h14; ack id 4 -> 8'h04; ack id 2 -> 8'h00; ack id 5 while not pending -> no change.
- Mask: pend 8'h21, mask=8'hFE -> pend_o=8'h20, en_o=1; mask=8'hDE -> pend_o=0, en_o=0; mask=8'hFF -> pend_o=8'h21 again.
- Set-wins-clear/overrun:
  - Second edge on line 3 while pending, no ack -> ovf_o=8'h08.
  - Edge on line 3 in the same cycle as ack id 3 -> pend stays 8'h08, no new ovf.
  - ovf_clr -> ovf_o=0.
- Reset mid-operation: pend_o=8'hFF, ovf_o=8'h01, assert rst_n=0 one cycle -> all outputs 0; lines still high after release -> each recaptured once, pend_o=8'hFF after SYNC_STAGES edges.
- Level mode, EDGE_MODE=0: hold irq_in[1]=1, ack id 1 -> pend_o[1] stays 1; drop line then ack -> pend_o[1]=0; ovf_o stays 0 throughout.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: constants and types shared by the request latch and the priority encoder
package irq_pkg;
   localparam int IRQ_N = 8;
   localparam int IRQ_IDW = 3;
   typedef logic [IRQ_N-1:0] irq_vec_t;
   typedef logic [IRQ_IDW-1:0] irq_id_t;
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: one request line through a flop synchroniser plus rising-edge detect
//   clk, rst_n : clock, synchronous active-low reset
//   d          : raw asynchronous request line
//   s          : synchronised line
//   rise       : s high this cycle and low the cycle before
module irq_sync_edge
   import irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic s,
   output logic rise
);
   logic s_d;
   if (SYNC_STAGES == 0) begin : g_pass
      assign s = d;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      logic [SYNC_STAGES:0] nxt;
      assign nxt = {chain, d};
      always_ff @(posedge clk) chain <= !rst_n ? '0 : nxt[SYNC_STAGES-1:0];
      assign s = chain[SYNC_STAGES-1];
   end
   // s_d resets low, so a line held high across reset release yields one edge
   always_ff @(posedge clk) s_d <= rst_n & s;
   assign rise = s & ~s_d;
endmodule

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: sticky per-line pending bits feeding the priority encoder
//   clk, rst_n      : clock, synchronous active-low reset
//   irq_in          : raw asynchronous request lines
//   mask            : 1 enables a line onto pend_o; never clears latched state
//   ack, ack_id     : one-cycle acknowledge of a single line by index
//   ovf_clr         : one-cycle strobe clearing every overrun flag
//   pend_o, en_o    : masked pending vector and its OR, to the encoder
//   ovf_o           : sticky overrun flags (edge mode only)
module irq_pending_latch
   import irq_pkg::*;
#(
   parameter int N = IRQ_N,
   parameter int IDW = IRQ_IDW,
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_MODE = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   irq_in,
   input  logic [N-1:0]   mask,
   input  logic           ack,
   input  logic [IDW-1:0] ack_id,
   input  logic           ovf_clr,
   output logic [N-1:0]   pend_o,
   output logic           en_o,
   output logic [N-1:0]   ovf_o
);
   logic [N-1:0] sync, rise, ev, clr, pend_q, ovf_q;
   for (genvar k = 0; k < N; k++) begin : g_line
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk(clk),
         .rst_n(rst_n),
         .d(irq_in[k]),
         .s(sync[k]),
         .rise(rise[k])
      );
   end
   assign ev = EDGE_MODE ? rise : sync;
   // out-of-range ids shift the one-hot past the top bit and clear nothing
   assign clr = ack ? {{(N-1){1'b0}}, 1'b1} << ack_id : '0;
   // a new event outranks a same-cycle ack, and an overrun outranks ovf_clr
   always_ff @(posedge clk) begin
      pend_q <= !rst_n ? '0 : (pend_q & ~clr) | ev;
      ovf_q <= (!rst_n || !EDGE_MODE) ? '0 : (ovf_q & ~{N{ovf_clr}}) | (ev & pend_q & ~clr);
   end
   assign pend_o = pend_q & mask;
   assign en_o = |pend_o;
   assign ovf_o = ovf_q;
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: edge-mode and level-mode latches driven in parallel against a request model
module tb_irq_pending_latch;
   localparam int SS = 2;
   logic clk = 1'b0, rst_n = 1'b0, ack = 1'b0, ovf_clr = 1'b0, live = 1'b0;
   logic [7:0] irq_in = '0, mask = 8'hFF;
   logic [2:0] ack_id = '0;
   logic [7:0] p0, o0, p1, o1;
   logic e0, e1;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   irq_pending_latch #(.SYNC_STAGES(SS), .EDGE_MODE(1'b1)) dut_edge (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .ack(ack), .ack_id(ack_id),
      .ovf_clr(ovf_clr), .pend_o(p0), .en_o(e0), .ovf_o(o0));
   irq_pending_latch #(.SYNC_STAGES(SS), .EDGE_MODE(1'b0)) dut_lvl (
      .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask), .ack(ack), .ack_id(ack_id),
      .ovf_clr(ovf_clr), .pend_o(p1), .en_o(e1), .ovf_o(o1));

   // request model: the line seen SS edges late; index 0 = edge mode, 1 = level mode
   logic [7:0] hist [SS];
   logic [7:0] prev_s = '0;
   logic [7:0] mp [2];
   logic [7:0] mo [2];
   initial begin
      for (int i = 0; i < SS; i++) hist[i] = '0;
      mp[0] = '0; mp[1] = '0; mo[0] = '0; mo[1] = '0;
   end

   always @(posedge clk) begin
      logic [7:0] s, ev, clr;
      if (!rst_n) begin
         for (int i = 0; i < SS; i++) hist[i] = '0;
         prev_s = '0;
         mp[0] = '0; mp[1] = '0; mo[0] = '0; mo[1] = '0;
      end else begin
         s = hist[SS-1];
         clr = ack ? (8'h01 << ack_id) : 8'h00;
         for (int m = 0; m < 2; m++) begin
            ev = (m == 0) ? (s & ~prev_s) : s;
            if (m == 0) mo[0] = (ovf_clr ? 8'h00 : mo[0]) | (ev & mp[0] & ~clr);
            mp[m] = (mp[m] & ~clr) | ev;
         end
         prev_s = s;
         for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = irq_in;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // a literal expectation checked against both the model and the DUT
   task automatic pin(input string name, input logic [7:0] model, input logic [7:0] dut, input logic [7:0] exp);
      chk({name, "/model"}, model, exp);
      chk({name, "/dut"}, dut, exp);
   endtask

   always @(negedge clk) if (live) begin
      chk("cmp pend edge", p0, mp[0] & mask);
      chk("cmp en edge", {7'd0, e0}, {7'd0, |(mp[0] & mask)});
      chk("cmp ovf edge", o0, mo[0]);
      chk("cmp pend lvl", p1, mp[1] & mask);
      chk("cmp en lvl", {7'd0, e1}, {7'd0, |(mp[1] & mask)});
      chk("cmp ovf lvl", o1, mo[1]);
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse(input logic [7:0] v);
      irq_in = v;
      cyc();
      irq_in = '0;
      cyc(2);
   endtask

   task automatic do_ack(input logic [2:0] id);
      ack = 1'b1;
      ack_id = id;
      cyc();
      ack = 1'b0;
   endtask

   initial begin
      cyc(2);
      live = 1'b1;
      rst_n = 1'b1;
      #1;
      pin("reset pend", mp[0] & mask, p0, 8'h00);
      pin("reset en", {7'd0, |(mp[0] & mask)}, {7'd0, e0}, 8'h00);
      pin("reset ovf", mo[0], o0, 8'h00);
      cyc();
      // single edge on line 7
      irq_in = 8'h80;
      cyc();
      irq_in = '0;
      cyc();
      #1 pin("lat one", mp[0], p0, 8'h00);
      cyc();
      #1 pin("lat two", mp[0], p0, 8'h80);
      pin("lat en", {7'd0, |mp[0]}, {7'd0, e0}, 8'h01);
      do_ack(3'd7);
      #1 pin("ack7", mp[0], p0, 8'h00);
      pin("ack7 en", {7'd0, |mp[0]}, {7'd0, e0}, 8'h00);
      // several pending
      pulse(8'h14);
      #1 pin("multi", mp[0], p0, 8'h14);
      do_ack(3'd4);
      #1 pin("ack4", mp[0], p0, 8'h04);
      do_ack(3'd2);
      #1 pin("ack2", mp[0], p0, 8'h00);
      do_ack(3'd5);
      #1 pin("ack5 idle", mp[0], p0, 8'h00);
      // masking
      pulse(8'h21);
      mask = 8'hFE;
      #1 pin("mask fe", mp[0] & mask, p0, 8'h20);
      pin("mask fe en", {7'd0, |(mp[0] & mask)}, {7'd0, e0}, 8'h01);
      mask = 8'hDE;
      #1 pin("mask de", mp[0] & mask, p0, 8'h00);
      pin("mask de en", {7'd0, |(mp[0] & mask)}, {7'd0, e0}, 8'h00);
      mask = 8'hFF;
      #1 pin("mask ff", mp[0] & mask, p0, 8'h21);
      do_ack(3'd0);
      do_ack(3'd5);
      // overrun, ovf_clr, set wins over clear
      pulse(8'h08);
      pulse(8'h08);
      #1 pin("ovf set", mo[0], o0, 8'h08);
      pin("ovf pend", mp[0], p0, 8'h08);
      pin("ovf lvl", mo[1], o1, 8'h00);
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      #1 pin("ovf clr", mo[0], o0, 8'h00);
      irq_in = 8'h08;
      cyc();
      irq_in = '0;
      cyc();
      do_ack(3'd3);
      #1 pin("set wins", mp[0], p0, 8'h08);
      pin("set wins ovf", mo[0], o0, 8'h00);
      do_ack(3'd3);
      // reset mid-operation
      irq_in = 8'hFF;
      cyc(3);
      irq_in = 8'hFE;
      cyc();
      irq_in = 8'hFF;
      cyc(3);
      #1 pin("pre rst pend", mp[0], p0, 8'hFF);
      pin("pre rst ovf", mo[0], o0, 8'h01);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      #1 pin("rst pend", mp[0], p0, 8'h00);
      pin("rst ovf", mo[0], o0, 8'h00);
      pin("rst lvl", mp[1], p1, 8'h00);
      cyc(2);
      #1 pin("recap early", mp[0], p0, 8'h00);
      cyc();
      #1 pin("recap", mp[0], p0, 8'hFF);
      pin("recap ovf", mo[0], o0, 8'h00);
      irq_in = '0;
      cyc(3);
      for (int i = 0; i < 8; i++) do_ack(3'(i));
      #1 pin("drained", mp[0] | mp[1], p0 | p1, 8'h00);
      // level mode
      irq_in = 8'h02;
      cyc(3);
      do_ack(3'd1);
      #1 pin("lvl held", mp[1], p1, 8'h02);
      pin("lvl edge acked", mp[0], p0, 8'h00);
      irq_in = '0;
      cyc(3);
      do_ack(3'd1);
      #1 pin("lvl dropped", mp[1], p1, 8'h00);
      pin("lvl ovf", mo[1], o1, 8'h00);
      cyc(2);
      live = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
